// File: rtl/multdiv_seq_unit_pkg.sv
// Shared encodings for the sequential multiply/divide unit: operation codes,
// controller states and divider iteration sizing.
package multdiv_seq_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FIXUP
    } mdState_e;

    localparam int DIV_ITER  = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITER + 1);

endpackage

// File: rtl/multdiv_seq_unit_div_restoring_core.sv
// Unsigned restoring divider: one quotient bit per cycle on magnitudes.
// The first iteration is folded into the load edge, so 32 bits are ready after 31 more edges.
module div_restoring_core
    import multdiv_seq_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    localparam logic [DIV_CNT_W-1:0] LAST_ITER = DIV_CNT_W'(DIV_ITER);

    logic [DIV_CNT_W-1:0] iterCnt;
    logic [31:0]          remReg;
    logic [31:0]          quoReg;
    logic [31:0]          divReg;
    logic [63:0]          loadStep;
    logic [63:0]          iterStep;

    // Quotient bits are shifted into the register that shifts the dividend out.
    function automatic logic [63:0] restoreStep(input logic [31:0] r, input logic [31:0] q,
                                                input logic [31:0] d);
        logic [32:0] trial;
        logic [32:0] diff;
        trial = {r, q[31]};
        diff  = trial - {1'b0, d};
        if (!diff[32]) return {diff[31:0], q[30:0], 1'b1};
        return {trial[31:0], q[30:0], 1'b0};
    endfunction

    assign loadStep  = restoreStep(32'd0, dividend, divisor);
    assign iterStep  = restoreStep(remReg, quoReg, divReg);
    assign quotient  = quoReg;
    assign remainder = remReg;
    assign done      = (iterCnt == LAST_ITER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iterCnt <= '0;
        end else if (abort) begin
            iterCnt <= '0;
        end else if (load) begin
            iterCnt <= DIV_CNT_W'(1);
        end else if (iterCnt == LAST_ITER) begin
            iterCnt <= '0;
        end else if (iterCnt != '0) begin
            iterCnt <= iterCnt + DIV_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            {remReg, quoReg} <= loadStep;
            divReg           <= divisor;
        end else if (iterCnt != '0 && iterCnt != LAST_ITER) begin
            {remReg, quoReg} <= iterStep;
        end
    end

endmodule

// File: rtl/multdiv_seq_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU responder for the EXE stage with busy/done handshakes.
// HI/LO are written on the edge that opens the done cycle and hold until the next completion.
module multdiv_seq_unit
    import multdiv_seq_unit_pkg::*;
#(
    parameter int          MULT_LAT    = 4,
    parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        flush,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mult_busy,
    output logic        div_busy,
    output logic        mult_done,
    output logic        div_done
);

    localparam logic [15:0] MULT_LAST = 16'(MULT_LAT);

    mdState_e           state;
    logic [15:0]        multCnt;
    logic               accept;
    logic               isSigned;
    logic signed [63:0] prodSigned;
    logic [63:0]        prodUnsigned;
    logic [63:0]        prodNow;
    logic [63:0]        prodReg;
    logic [31:0]        absA;
    logic [31:0]        absB;
    logic [31:0]        opaLat;
    logic               aNegLat;
    logic               bNegLat;
    logic               bZeroLat;
    logic [31:0]        coreQuo;
    logic [31:0]        coreRem;
    logic               coreDone;
    logic [31:0]        divHi;
    logic [31:0]        divLo;

    function automatic logic [31:0] negate(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    assign accept       = (state == ST_IDLE) && start && !flush;
    assign isSigned     = (op == MD_MULT) || (op == MD_DIV);
    assign prodSigned   = $signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb});
    assign prodUnsigned = {32'd0, opa} * {32'd0, opb};
    assign prodNow      = isSigned ? $unsigned(prodSigned) : prodUnsigned;
    assign absA         = (isSigned && opa[31]) ? negate(opa) : opa;
    assign absB         = (isSigned && opb[31]) ? negate(opb) : opb;

    // Operands are captured at acceptance so opa/opb may change during the operation.
    always_ff @(posedge clk) begin
        if (accept) begin
            prodReg  <= prodNow;
            opaLat   <= opa;
            aNegLat  <= isSigned & opa[31];
            bNegLat  <= isSigned & opb[31];
            bZeroLat <= (opb == 32'd0);
        end
    end

    div_restoring_core uDivCore (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && op[1]),
        .abort     (flush),
        .dividend  (absA),
        .divisor   (absB),
        .quotient  (coreQuo),
        .remainder (coreRem),
        .done      (coreDone)
    );

    // Sign fix-up; 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    always_comb begin
        divHi = coreRem;
        divLo = coreQuo;
        if (bZeroLat) begin
            divHi = opaLat;
            divLo = DIV_ZERO_LO;
        end else begin
            if (aNegLat ^ bNegLat) divLo = negate(coreQuo);
            if (aNegLat)           divHi = negate(coreRem);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            multCnt   <= '0;
            hi        <= '0;
            lo        <= '0;
            mult_busy <= 1'b0;
            div_busy  <= 1'b0;
            mult_done <= 1'b0;
            div_done  <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            multCnt   <= '0;
            mult_busy <= 1'b0;
            div_busy  <= 1'b0;
            mult_done <= 1'b0;
            div_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !op[1]) begin
                        state     <= ST_MULT;
                        mult_busy <= 1'b1;
                        multCnt   <= 16'd1;
                        if (MULT_LAT == 1) begin
                            {hi, lo}  <= prodNow;
                            mult_done <= 1'b1;
                        end
                    end else if (start) begin
                        state    <= ST_DIV;
                        div_busy <= 1'b1;
                    end
                end
                ST_MULT: begin
                    if (multCnt == MULT_LAST) begin
                        state     <= ST_IDLE;
                        multCnt   <= '0;
                        mult_busy <= 1'b0;
                        mult_done <= 1'b0;
                    end else begin
                        multCnt <= multCnt + 16'd1;
                        if (multCnt + 16'd1 == MULT_LAST) begin
                            {hi, lo}  <= prodReg;
                            mult_done <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    if (coreDone) begin
                        state    <= ST_FIXUP;
                        {hi, lo} <= {divHi, divLo};
                        div_done <= 1'b1;
                    end
                end
                ST_FIXUP: begin
                    state    <= ST_IDLE;
                    div_busy <= 1'b0;
                    div_done <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq_unit.sv
// Directed bench for multdiv_seq_unit: hand-computed results, handshake timing,
// ignored starts, flush and asynchronous reset behaviour.
module tb_multdiv_seq_unit;
    import multdiv_seq_unit_pkg::*;

    localparam int MLAT = 4;
    localparam int DLAT = 33;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        flush;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mult_busy;
    logic        div_busy;
    logic        mult_done;
    logic        div_done;

    int checks = 0;
    int errors = 0;

    multdiv_seq_unit #(.MULT_LAT(MLAT), .DIV_ZERO_LO(32'hFFFF_FFFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .flush     (flush),
        .opa       (opa),
        .opb       (opb),
        .hi        (hi),
        .lo        (lo),
        .mult_busy (mult_busy),
        .div_busy  (div_busy),
        .mult_done (mult_done),
        .div_done  (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op and watch it for n+3 cycles; optionally pulse a competing start in cycle injectAt.
    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [31:0] eHi,
                         input logic [31:0] eLo, input int injectAt);
        int doneAt, doneCnt, busyCnt, wrong;
        logic [31:0] capHi, capLo;
        logic myBusy, myDone, otherAct;
        doneAt = 0; doneCnt = 0; busyCnt = 0; wrong = 0; capHi = '0; capLo = '0;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0; opa = $urandom; opb = $urandom;
        for (int c = 1; c <= n + 3; c++) begin
            myBusy   = o[1] ? div_busy  : mult_busy;
            myDone   = o[1] ? div_done  : mult_done;
            otherAct = o[1] ? (mult_busy | mult_done) : (div_busy | div_done);
            if (myDone) begin
                doneCnt++; doneAt = c; capHi = hi; capLo = lo;
                if (!myBusy) wrong++;
            end
            if (myBusy) busyCnt++;
            if (otherAct) wrong++;
            if (c == injectAt) begin
                start = 1'b1; op = MD_MULT; opa = $urandom; opb = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check({tag, "/doneAt"},  64'(doneAt),  64'(n));
        check({tag, "/doneCnt"}, 64'(doneCnt), 64'd1);
        check({tag, "/busyCnt"}, 64'(busyCnt), 64'(n));
        check({tag, "/other"},   64'(wrong),   64'd0);
        check({tag, "/hi"},      64'(capHi),   64'(eHi));
        check({tag, "/lo"},      64'(capLo),   64'(eLo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int act;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset/hi", 64'(hi), 64'd0);
        check("reset/lo", 64'(lo), 64'd0);
        check("reset/flags", 64'({mult_busy, div_busy, mult_done, div_done}), 64'd0);

        runOp("mult",     MD_MULT,  32'hFFFF_FFFD, 32'd7,         MLAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        runOp("multu",    MD_MULTU, 32'hFFFF_FFFF, 32'd2,         MLAT, 32'h0000_0001, 32'hFFFF_FFFE, 0);
        runOp("div",      MD_DIV,   32'hFFFF_FFF9, 32'd2,         DLAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        runOp("divu",     MD_DIVU,  32'd100,       32'd7,         DLAT, 32'd2,         32'd14,        0);
        runOp("div0",     MD_DIV,   32'h1234_5678, 32'd0,         DLAT, 32'h1234_5678, 32'hFFFF_FFFF, 0);
        runOp("divovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DLAT, 32'd0,         32'h8000_0000, 0);
        runOp("injBusy",  MD_DIVU,  32'd100,       32'd7,         DLAT, 32'd2,         32'd14,        10);
        runOp("injDone",  MD_DIV,   32'hFFFF_FFF9, 32'd2,         DLAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DLAT);

        // Flush sampled at the edge ending cycle 15 of a divide.
        @(negedge clk);
        start = 1'b1; op = MD_DIVU; opa = 32'd1000; opb = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush/flags", 64'({mult_busy, div_busy, mult_done, div_done}), 64'd0);
        check("flush/hi", 64'(hi), 64'hFFFF_FFFF);
        check("flush/lo", 64'(lo), 64'hFFFF_FFFD);
        runOp("postFlush", MD_MULT, 32'd5, 32'd6, MLAT, 32'd0, 32'd30, 0);
        act = 0;
        for (int c = 0; c < 15; c++) begin
            if (div_busy | div_done) act++;
            @(posedge clk); #1;
        end
        check("flush/noDiv", 64'(act), 64'd0);

        // start and flush together in IDLE: not accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = MD_MULT; opa = 32'd9; opb = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        act = 0;
        for (int c = 0; c < MLAT + 2; c++) begin
            if (mult_busy | mult_done | div_busy | div_done) act++;
            @(posedge clk); #1;
        end
        check("startFlush/act", 64'(act), 64'd0);
        check("startFlush/lo", 64'(lo), 64'd30);

        // Asynchronous reset in the middle of cycle 15 of a divide.
        @(negedge clk);
        start = 1'b1; op = MD_DIV; opa = 32'd77; opb = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("preRst/divBusy", 64'(div_busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst/hi", 64'(hi), 64'd0);
        check("rst/lo", 64'(lo), 64'd0);
        check("rst/flags", 64'({mult_busy, div_busy, mult_done, div_done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        act = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (mult_busy | mult_done | div_busy | div_done) act++;
        end
        check("rst/discarded", 64'(act), 64'd0);
        runOp("postRst", MD_MULTU, 32'h0001_0000, 32'h0001_0000, MLAT, 32'd1, 32'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
